// File: rtl/mem_arb_pkg.sv
// Shared types and default limits for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_STARVE_LIMIT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, memory-stage and unified memory port signals; slave is the arbiter's view,
// master is the view of the requesters and the memory together.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        bus_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/timeout_counter.sv
// Counts cycles while enabled; expired flags the last allowed cycle (count == TIMEOUT-1).
module timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    // Hold at the limit so a stalled owner cannot wrap back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the memory stage (D),
// with D priority, starvation relief for I and a bus timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 2);

    arb_state_e    state;
    owner_e        owner;
    logic [SW-1:0] d_streak;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          mem_req_q;
    logic          if_ready_q;
    logic          dm_ready_q;
    logic          bus_err_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   dm_rdata_q;

    logic          starved;
    logic          i_wins;
    logic          expired;
    logic          tmo_en;
    logic          tmo_clr;
    logic          done;
    logic [31:0]   resp_data;

    assign starved   = (d_streak == SW'(STARVE_LIMIT));
    assign i_wins    = bus.if_req && (!bus.dm_req || starved);
    assign done      = bus.mem_ack || expired;
    assign resp_data = bus.mem_ack ? bus.mem_rdata : '0;

    // The counter only runs inside BUSY and restarts for every transaction.
    assign tmo_en  = (state == BUSY);
    assign tmo_clr = (state != BUSY) || done;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (tmo_en),
        .clear   (tmo_clr),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_I;
            d_streak   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            // Completion strobes live for the single RESP cycle only.
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.if_req) d_streak <= '0;
                    if (bus.if_req || bus.dm_req) begin
                        state     <= BUSY;
                        mem_req_q <= 1'b1;
                        if (i_wins) begin
                            owner    <= OWN_I;
                            addr_q   <= bus.if_addr;
                            we_q     <= 1'b0;
                            wdata_q  <= '0;
                            d_streak <= '0;
                        end else begin
                            owner   <= OWN_D;
                            addr_q  <= bus.dm_addr;
                            we_q    <= bus.dm_we;
                            wdata_q <= bus.dm_wdata;
                            if (bus.if_req && !starved) d_streak <= d_streak + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // mem_ack takes precedence over a coincident timeout.
                    if (done) begin
                        state     <= RESP;
                        mem_req_q <= 1'b0;
                        we_q      <= 1'b0;
                        bus_err_q <= !bus.mem_ack;
                        if (owner == OWN_I) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= resp_data;
                        end else begin
                            dm_ready_q <= 1'b1;
                            dm_rdata_q <= resp_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                    we_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4 and STARVE_LIMIT=2.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(
        .TIMEOUT      (4),
        .STARVE_LIMIT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        want_d;
        int          req_cycles;
        total = 0;
        bad   = 0;

        reset             = 1'b1;
        bus_if.if_req     = 1'b0;
        bus_if.if_addr    = '0;
        bus_if.dm_req     = 1'b0;
        bus_if.dm_we      = 1'b0;
        bus_if.dm_addr    = '0;
        bus_if.dm_wdata   = '0;
        bus_if.mem_ack    = 1'b0;
        bus_if.mem_rdata  = '0;
        tick;
        tick;

        // Reset state
        check("rst_mem_req",  32'(bus_if.mem_req),  32'h0);
        check("rst_mem_we",   32'(bus_if.mem_we),   32'h0);
        check("rst_if_ready", 32'(bus_if.if_ready), 32'h0);
        check("rst_dm_ready", 32'(bus_if.dm_ready), 32'h0);
        check("rst_bus_err",  32'(bus_if.bus_err),  32'h0);
        check("rst_if_rdata", bus_if.if_rdata,      32'h0);
        check("rst_dm_rdata", bus_if.dm_rdata,      32'h0);
        check("rst_mem_addr", bus_if.mem_addr,      32'h0);
        reset = 1'b0;
        tick;

        // Fetch read, ack two cycles after mem_req
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0040;
        tick;
        check("f_mem_req",  32'(bus_if.mem_req), 32'h1);
        check("f_mem_addr", bus_if.mem_addr,     32'h40);
        check("f_mem_we",   32'(bus_if.mem_we),  32'h0);
        tick;
        check("f_no_ready", 32'(bus_if.if_ready), 32'h0);
        tick;
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h2008_0005;
        tick;
        bus_if.mem_ack = 1'b0;
        check("f_if_ready", 32'(bus_if.if_ready), 32'h1);
        check("f_if_rdata", bus_if.if_rdata,      32'h2008_0005);
        check("f_dm_ready", 32'(bus_if.dm_ready), 32'h0);
        check("f_bus_err",  32'(bus_if.bus_err),  32'h0);
        check("f_req_low",  32'(bus_if.mem_req),  32'h0);
        bus_if.if_req = 1'b0;
        tick;
        check("f_ready_1cyc", 32'(bus_if.if_ready), 32'h0);
        tick;

        // Simultaneous requests: D store first, then I
        bus_if.dm_req   = 1'b1;
        bus_if.dm_we    = 1'b1;
        bus_if.dm_addr  = 32'h0000_0100;
        bus_if.dm_wdata = 32'hDEAD_BEEF;
        bus_if.if_req   = 1'b1;
        bus_if.if_addr  = 32'h0000_0080;
        tick;
        check("s_mem_we",    32'(bus_if.mem_we), 32'h1);
        check("s_mem_addr",  bus_if.mem_addr,    32'h100);
        check("s_mem_wdata", bus_if.mem_wdata,   32'hDEAD_BEEF);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h0000_0011;
        tick;
        bus_if.mem_ack = 1'b0;
        check("s_dm_ready", 32'(bus_if.dm_ready), 32'h1);
        check("s_if_idle",  32'(bus_if.if_ready), 32'h0);
        check("s_we_low",   32'(bus_if.mem_we),   32'h0);
        bus_if.dm_req = 1'b0;
        bus_if.dm_we  = 1'b0;
        tick;
        tick;
        check("s_i_addr", bus_if.mem_addr,    32'h80);
        check("s_i_we",   32'(bus_if.mem_we), 32'h0);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h1234_5678;
        tick;
        bus_if.mem_ack = 1'b0;
        check("s_if_ready",  32'(bus_if.if_ready), 32'h1);
        check("s_if_rdata",  bus_if.if_rdata,      32'h1234_5678);
        check("s_dm_rdata_hold", bus_if.dm_rdata,  32'h0000_0011);
        bus_if.if_req = 1'b0;
        tick;
        tick;

        // Continuous D traffic with I pending: D, D, I, D, D, I
        bus_if.dm_req  = 1'b1;
        bus_if.dm_addr = 32'h0000_0200;
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0300;
        for (int i = 0; i < 6; i++) begin
            want_d = ((i % 3) != 2);
            tick;
            check($sformatf("g%0d_addr", i), bus_if.mem_addr, want_d ? 32'h200 : 32'h300);
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = 32'h0000_0A00 + 32'(i);
            tick;
            bus_if.mem_ack = 1'b0;
            check($sformatf("g%0d_dm_ready", i), 32'(bus_if.dm_ready), 32'(want_d));
            check($sformatf("g%0d_if_ready", i), 32'(bus_if.if_ready), 32'(!want_d));
            tick;
        end
        bus_if.dm_req = 1'b0;
        bus_if.if_req = 1'b0;
        tick;

        // No ack: timeout after exactly 4 BUSY cycles
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0400;
        tick;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_if.mem_req) req_cycles++;
            tick;
        end
        check("t_req_cycles", 32'(req_cycles),       32'd4);
        check("t_if_ready",   32'(bus_if.if_ready),  32'h1);
        check("t_bus_err",    32'(bus_if.bus_err),   32'h1);
        check("t_if_rdata",   bus_if.if_rdata,       32'h0);
        check("t_req_low",    32'(bus_if.mem_req),   32'h0);
        bus_if.if_req = 1'b0;
        tick;
        check("t_err_clear",  32'(bus_if.bus_err),   32'h0);
        check("t_ready_clear", 32'(bus_if.if_ready), 32'h0);
        tick;

        // Ack coincides with the last timeout cycle: ack wins
        bus_if.dm_req  = 1'b1;
        bus_if.dm_we   = 1'b0;
        bus_if.dm_addr = 32'h0000_0500;
        tick;
        tick;
        tick;
        tick;
        check("c_still_busy", 32'(bus_if.mem_req), 32'h1);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hCAFE_F00D;
        tick;
        bus_if.mem_ack = 1'b0;
        check("c_dm_ready", 32'(bus_if.dm_ready), 32'h1);
        check("c_bus_err",  32'(bus_if.bus_err),  32'h0);
        check("c_dm_rdata", bus_if.dm_rdata,      32'hCAFE_F00D);
        bus_if.dm_req = 1'b0;
        tick;
        tick;

        // Reset during BUSY, then a stray ack
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0600;
        tick;
        check("r_busy", 32'(bus_if.mem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("r_async_req", 32'(bus_if.mem_req), 32'h0);
        bus_if.if_req = 1'b0;
        tick;
        reset = 1'b0;
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h5555_AAAA;
        tick;
        bus_if.mem_ack = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus_if.if_ready || bus_if.dm_ready || bus_if.bus_err || bus_if.mem_req)
                req_cycles++;
            tick;
        end
        check("r_quiet",     32'(req_cycles),  32'd0);
        check("r_if_rdata",  bus_if.if_rdata,  32'h0);
        check("r_dm_rdata",  bus_if.dm_rdata,  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles in BUSY without mem_ack.
REQ-002 SHALL have parameter STARVE_LIMIT, default 2, giving the consecutive data grants allowed while if_req waits.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_req, if_addr  input  1, 32  fetch-side read request and byte address.
REQ-007 if_ready, if_rdata  output  1, 32  fetch completion pulse and read data.
REQ-008 dm_req, dm_we, dm_addr, dm_wdata  input  1, 1, 32, 32  memory-stage request, write enable, address and store data.
REQ-009 dm_ready, dm_rdata  output  1, 32  memory-stage completion pulse and load data.
REQ-010 mem_req, mem_we, mem_addr, mem_wdata  output  1, 1, 32, 32  unified memory port command.
REQ-011 mem_ack, mem_rdata  input  1, 32  one-cycle completion strobe from memory, and read data valid with it.
REQ-012 bus_err  output  1  high together with the ready pulse of a timed-out transaction.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and RESP, plus a 1-bit owner register (I or D).
REQ-014 In IDLE with any request present: latch owner, address, we and wdata; next state BUSY. Otherwise stay in IDLE.
REQ-015 Grant priority: D wins over I, unless d_streak equals STARVE_LIMIT and if_req is high, in which case I wins.
REQ-016 d_streak: increments (saturating) on each D grant while if_req is high; clears on any I grant or when if_req is low in IDLE.
REQ-017 In BUSY: mem_req=1, and mem_addr, mem_we, mem_wdata come from the latched values. mem_we=0 whenever owner=I.
REQ-018 In BUSY with mem_ack: register mem_rdata into the owner's rdata register; next state RESP.
REQ-019 In BUSY: the timeout counter increments each cycle. At count==TIMEOUT-1 without mem_ack: next state RESP, set bus_err, rdata=0.
REQ-020 If mem_ack arrives in the same cycle the timeout limit is reached, mem_ack wins and bus_err stays 0.
REQ-021 In RESP: the owner's ready=1 for exactly one cycle, bus_err as latched; next state IDLE. mem_req=0.
REQ-022 Latency: request sampled in IDLE at cycle N; mem_req high at N+1; mem_ack at N+1+k; ready at N+2+k.
REQ-023 Requesters hold req/addr/data until ready. Any change is permitted in the cycle after ready.
REQ-024 A request dropped during BUSY does not abort the transaction; ready still pulses in RESP.
REQ-025 if_rdata and dm_rdata hold their last value until the next completion for that port.
REQ-026 if_ready, dm_ready and bus_err are never high outside RESP. At most one ready is high per cycle.

Reset
REQ-027 On reset assertion, immediately: state=IDLE, mem_req=0, mem_we=0, ready outputs=0, bus_err=0, counters=0, d_streak=0, rdata registers=0, latched address/data=0.
REQ-028 Reset mid-BUSY abandons the transaction with no ready pulse. A late mem_ack arriving in IDLE is ignored.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY, RESP), the owner enum (OWN_I, OWN_D) and the default TIMEOUT and STARVE_LIMIT constants.
REQ-030 The timeout counter SHALL be a sub-module, timeout_counter. It has enable, clear and expired, and is parameterised by TIMEOUT.
REQ-031 Hazard-unit stall generation stays outside this block. Stall is derived from req & ~ready.

Verification
REQ-032 if_req only, if_addr=0x0000_0040, mem_ack 2 cycles after mem_req with rdata 0x2008_0005 -> mem_addr=0x40, mem_we=0, if_ready at N+4 with if_rdata=0x2008_0005.
REQ-033 dm_req and if_req both high in the same cycle, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, ack k=0 -> D served first (mem_we=1, mem_wdata=0xDEAD_BEEF, dm_ready at N+2); I served next.
REQ-034 dm_req held continuously with if_req pending, STARVE_LIMIT=2 -> grant order D, D, I, D, D, I.
REQ-035 No mem_ack, TIMEOUT=4 -> mem_req high for exactly 4 cycles, then owner ready=1 with bus_err=1 and rdata=0; next cycle IDLE.
REQ-036 mem_ack coincident with the final timeout cycle -> bus_err=0 and rdata=mem_rdata.
REQ-037 Reset asserted during BUSY, then mem_ack pulsed after release -> mem_req low immediately, no ready, state IDLE.
